// File: rtl/codec_frame_sched_pkg.sv
// Shared definitions for the CODEC frame scheduler.
// - DATA_W        default sample width
// - CH_LFT/CH_RHT engine channel select encodings
// - sched_state_t scheduler state encoding
package audio_pkg;

   localparam int DATA_W = 16;

   localparam logic CH_LFT = 1'b0;
   localparam logic CH_RHT = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      L_REQ  = 3'd1,
      L_WAIT = 3'd2,
      R_REQ  = 3'd3,
      R_WAIT = 3'd4,
      COMMIT = 3'd5
   } sched_state_t;

endpackage

// File: rtl/codec_frame_sched_if.sv
// Request/response bus between the frame scheduler and the shared audio engine.
// Signals:
// - eng_start  1-clk request pulse (scheduler -> engine)
// - eng_ch     channel select, 0 = left, 1 = right (scheduler -> engine)
// - eng_din    sample to process (scheduler -> engine)
// - eng_done   1-clk completion pulse (engine -> scheduler)
// - eng_dout   processed sample, valid while eng_done = 1 (engine -> scheduler)
// Modports: master = scheduler side, slave = engine side.
interface codec_frame_sched_if
   import audio_pkg::*;
#(
   parameter int DW = DATA_W
);
   logic          eng_start;
   logic          eng_ch;
   logic [DW-1:0] eng_din;
   logic          eng_done;
   logic [DW-1:0] eng_dout;

   modport master (
      output eng_start,
      output eng_ch,
      output eng_din,
      input  eng_done,
      input  eng_dout
   );

   modport slave (
      input  eng_start,
      input  eng_ch,
      input  eng_din,
      output eng_done,
      output eng_dout
   );

endinterface

// File: rtl/codec_frame_sched_timeout.sv
// sched_timeout: loadable up-counter with a terminal flag, used to bound how
// long the scheduler waits for the engine.
// Ports:
// - clk, rst_n  clock, asynchronous active-low reset
// - load        clear the count to zero (issued with each engine request)
// - en          count this cycle (scheduler is waiting for the engine)
// - tc          terminal: this is the LIMIT-th enabled cycle since load
module sched_timeout #(
   parameter int LIMIT = 768,
   parameter int CNT_W = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_r;

   // Wait-cycle counter; holds at LAST so it can never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= '0;
      end else if (en && (cnt_r != LAST)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Flag the cycle in which the LIMIT-th wait cycle elapses.
   assign tc = en && (cnt_r == LAST);

endmodule

// File: rtl/codec_frame_sched.sv
// codec_frame_sched: per-frame scheduler between the CODEC interface and one
// shared audio engine. Each valid pulse latches a stereo pair, runs left then
// right through the engine, and commits the processed pair to lft_out/rht_out.
// The first WARM_FRAMES commits after reset are muted to zero.
// Ports:
// - clk, rst_n          clock, asynchronous active-low reset
// - valid               1-clk pulse: lft_in/rht_in hold a new frame
// - lft_in, rht_in      samples from the CODEC
// - lft_out, rht_out    processed samples, updated only at frame commit
// - eng                 engine request/response bus (master side)
// - busy                a frame is in flight
// - err_ovr             sticky: valid arrived while busy (sample dropped)
// - err_tmo             sticky: engine did not answer within TMO_CYC cycles
// - clr_err             synchronous clear of both sticky flags (set wins)
module codec_frame_sched
   import audio_pkg::*;
#(
   parameter int DATA_W      = audio_pkg::DATA_W,
   parameter int WARM_FRAMES = 4,
   parameter int TMO_CYC     = 768
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic [DATA_W-1:0] lft_in,
   input  logic [DATA_W-1:0] rht_in,
   output logic [DATA_W-1:0] lft_out,
   output logic [DATA_W-1:0] rht_out,
   codec_frame_sched_if.master eng,
   output logic              busy,
   output logic              err_ovr,
   output logic              err_tmo,
   input  logic              clr_err
);

   localparam int WARM_W = $clog2(WARM_FRAMES + 1);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_FRAMES);

   sched_state_t      state_r;
   logic [DATA_W-1:0] lft_buf_r;
   logic [DATA_W-1:0] rht_buf_r;
   logic [DATA_W-1:0] lft_res_r;
   logic [DATA_W-1:0] rht_res_r;
   logic [WARM_W-1:0] warm_r;
   logic [DATA_W-1:0] lft_out_r;
   logic [DATA_W-1:0] rht_out_r;
   logic              eng_start_r;
   logic              eng_ch_r;
   logic [DATA_W-1:0] eng_din_r;
   logic              busy_r;
   logic              err_ovr_r;
   logic              err_tmo_r;

   logic              waiting_s;
   logic              tc_s;

   assign waiting_s = (state_r == L_WAIT) || (state_r == R_WAIT);

   sched_timeout #(
      .LIMIT (TMO_CYC)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (eng_start_r),
      .en    (waiting_s),
      .tc    (tc_s)
   );

   // Frame FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         lft_buf_r   <= '0;
         rht_buf_r   <= '0;
         lft_res_r   <= '0;
         rht_res_r   <= '0;
         warm_r      <= '0;
         lft_out_r   <= '0;
         rht_out_r   <= '0;
         eng_start_r <= 1'b0;
         eng_ch_r    <= CH_LFT;
         eng_din_r   <= '0;
         busy_r      <= 1'b0;
         err_ovr_r   <= 1'b0;
         err_tmo_r   <= 1'b0;
      end else begin
         eng_start_r <= 1'b0;

         // Clear first so that a set later in this block overrides it.
         if (clr_err) begin
            err_ovr_r <= 1'b0;
            err_tmo_r <= 1'b0;
         end
         if (valid && (state_r != IDLE)) begin
            err_ovr_r <= 1'b1;
         end

         case (state_r)
            IDLE: begin
               if (valid) begin
                  lft_buf_r   <= lft_in;
                  rht_buf_r   <= rht_in;
                  eng_start_r <= 1'b1;
                  eng_ch_r    <= CH_LFT;
                  eng_din_r   <= lft_in;
                  busy_r      <= 1'b1;
                  state_r     <= L_REQ;
               end
            end
            L_REQ: begin
               state_r <= L_WAIT;
            end
            L_WAIT: begin
               // Done in the terminal cycle still counts as an answer.
               if (eng.eng_done || tc_s) begin
                  if (eng.eng_done) begin
                     lft_res_r <= eng.eng_dout;
                  end else begin
                     err_tmo_r <= 1'b1;
                  end
                  eng_start_r <= 1'b1;
                  eng_ch_r    <= CH_RHT;
                  eng_din_r   <= rht_buf_r;
                  state_r     <= R_REQ;
               end
            end
            R_REQ: begin
               state_r <= R_WAIT;
            end
            R_WAIT: begin
               if (eng.eng_done || tc_s) begin
                  if (eng.eng_done) begin
                     rht_res_r <= eng.eng_dout;
                  end else begin
                     err_tmo_r <= 1'b1;
                  end
                  state_r <= COMMIT;
               end
            end
            COMMIT: begin
               if (warm_r < WARM_LAST) begin
                  lft_out_r <= '0;
                  rht_out_r <= '0;
                  warm_r    <= warm_r + WARM_W'(1);
               end else begin
                  lft_out_r <= lft_res_r;
                  rht_out_r <= rht_res_r;
               end
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign lft_out       = lft_out_r;
   assign rht_out       = rht_out_r;
   assign eng.eng_start = eng_start_r;
   assign eng.eng_ch    = eng_ch_r;
   assign eng.eng_din   = eng_din_r;
   assign busy          = busy_r;
   assign err_ovr       = err_ovr_r;
   assign err_tmo       = err_tmo_r;

endmodule

// File: tb/tb_codec_frame_sched.sv
// Self-checking bench for codec_frame_sched: directed scenarios plus random
// frames, checked against a frame-level reference model.
module tb_codec_frame_sched;

   localparam int DW  = 16;
   localparam int TMO = 768;

   logic          clk;
   logic          rst_n;
   logic          valid;
   logic [DW-1:0] lft_in;
   logic [DW-1:0] rht_in;
   logic [DW-1:0] lft_out;
   logic [DW-1:0] rht_out;
   logic          busy;
   logic          err_ovr;
   logic          err_tmo;
   logic          clr_err;

   codec_frame_sched_if eng_bus ();

   codec_frame_sched dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (valid),
      .lft_in  (lft_in),
      .rht_in  (rht_in),
      .lft_out (lft_out),
      .rht_out (rht_out),
      .eng     (eng_bus),
      .busy    (busy),
      .err_ovr (err_ovr),
      .err_tmo (err_tmo),
      .clr_err (clr_err)
   );

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   // engine model controls and observations
   int            eng_dl = 0;   // left: done in wait cycle eng_dl+1; <0 = never
   int            eng_dr = 0;
   int            start_cyc [2];
   int            done_cyc  [2];
   bit            hold_bad = 1'b0;
   int            out_chg_cyc = -1;
   int            tmo_rise_cyc = -1;
   int            v_cyc = 0;

   // reference model state
   int            m_warm = 0;
   logic [DW-1:0] m_res_l = '0, m_res_r = '0;
   logic [DW-1:0] m_out_l = '0, m_out_r = '0;
   logic          m_tmo = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever @(posedge clk) cyc++;

   function automatic logic [DW-1:0] eng_f(input logic [DW-1:0] d);
      return d + 16'h0001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Engine: answers a request after a programmed delay, checks held inputs.
   initial begin : engine
      bit            pend;
      logic          p_ch;
      logic [DW-1:0] p_din;
      int            cnt;
      pend = 1'b0;
      p_ch = 1'b0;
      p_din = '0;
      cnt = 0;
      eng_bus.eng_done = 1'b0;
      eng_bus.eng_dout = '0;
      forever begin
         @(negedge clk);
         eng_bus.eng_done = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else if (eng_bus.eng_start) begin
            p_ch  = eng_bus.eng_ch;
            p_din = eng_bus.eng_din;
            cnt   = p_ch ? eng_dr : eng_dl;
            start_cyc[p_ch] = cyc;
            pend  = (cnt >= 0);
         end else if (pend) begin
            if (eng_bus.eng_ch !== p_ch || eng_bus.eng_din !== p_din) hold_bad = 1'b1;
            if (cnt == 0) begin
               eng_bus.eng_done = 1'b1;
               eng_bus.eng_dout = eng_f(p_din);
               done_cyc[p_ch] = cyc;
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // Records when the committed pair changes and when err_tmo rises.
   initial begin : monitor
      logic [2*DW-1:0] last;
      logic            last_tmo;
      last = '0;
      last_tmo = 1'b0;
      forever begin
         @(negedge clk);
         if ({lft_out, rht_out} !== last) begin
            out_chg_cyc = cyc;
            last = {lft_out, rht_out};
         end
         if (err_tmo && !last_tmo) tmo_rise_cyc = cyc;
         last_tmo = err_tmo;
      end
   end

   // Frame-level reference: a channel is answered iff done lands within TMO wait cycles.
   task automatic model_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int dl, input int dr);
      if (dl >= 0 && dl < TMO) m_res_l = eng_f(l); else m_tmo = 1'b1;
      if (dr >= 0 && dr < TMO) m_res_r = eng_f(r); else m_tmo = 1'b1;
      if (m_warm < 4) begin
         m_out_l = '0;
         m_out_r = '0;
         m_warm++;
      end else begin
         m_out_l = m_res_l;
         m_out_r = m_res_r;
      end
   endtask

   task automatic model_reset();
      m_warm = 0;
      m_res_l = '0;
      m_res_r = '0;
      m_out_l = '0;
      m_out_r = '0;
      m_tmo = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk({tag, "_idle_bound"}, 32'd0, 32'd1);
   endtask

   task automatic pulse_valid(input logic [DW-1:0] l, input logic [DW-1:0] r);
      @(negedge clk);
      valid  = 1'b1;
      lft_in = l;
      rht_in = r;
      v_cyc  = cyc;
      @(negedge clk);
      valid  = 1'b0;
   endtask

   task automatic frame(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r,
                        input int dl, input int dr);
      eng_dl = dl;
      eng_dr = dr;
      wait_idle({tag, "_pre"});
      pulse_valid(l, r);
      wait_idle(tag);
      model_frame(l, r, dl, dr);
      chk({tag, "_lft_out"}, 32'(lft_out), 32'(m_out_l));
      chk({tag, "_rht_out"}, 32'(rht_out), 32'(m_out_r));
      chk({tag, "_err_tmo"}, 32'(err_tmo), 32'(m_tmo));
   endtask

   initial begin : main
      logic [DW-1:0] a_l, a_r;
      rst_n   = 1'b0;
      valid   = 1'b0;
      lft_in  = '0;
      rht_in  = '0;
      clr_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_lft_out", 32'(lft_out), 32'd0);
      chk("rst_rht_out", 32'(rht_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_errs", 32'({err_ovr, err_tmo}), 32'd0);
      chk("rst_eng_start", 32'(eng_bus.eng_start), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // warm-up mute: four zero commits then pass-through
      for (int i = 0; i < 5; i++) frame("warm", 16'h1000, 16'h2000, 0, 0);
      chk("warm_f5_lft", 32'(lft_out), 32'h1001);
      chk("warm_f5_rht", 32'(rht_out), 32'h2001);

      // right channel never answered
      frame("tmo", 16'h5555, 16'h3333, 2, -1);
      chk("tmo_rht_held", 32'(rht_out), 32'h2001);
      chk("tmo_lft_new", 32'(lft_out), 32'h5556);
      chk("tmo_rise_cyc", 32'(tmo_rise_cyc), 32'(start_cyc[1] + TMO + 1));

      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      m_tmo = 1'b0;
      chk("clr_tmo", 32'(err_tmo), 32'd0);

      // done arrives in the terminal wait cycle on both channels
      frame("coinc", 16'h6000, 16'h7000, TMO - 1, TMO - 1);

      // ordering and latency with a 10-clk engine
      hold_bad = 1'b0;
      frame("order", 16'h3a3a, 16'h4b4b, 10, 10);
      chk("order_l_start", 32'(start_cyc[0]), 32'(v_cyc + 1));
      chk("order_l_done", 32'(done_cyc[0]), 32'(start_cyc[0] + 11));
      chk("order_r_start", 32'(start_cyc[1]), 32'(done_cyc[0] + 1));
      chk("order_out_upd", 32'(out_chg_cyc), 32'(done_cyc[1] + 2));
      chk("order_hold", 32'(hold_bad), 32'd0);

      // overrun during L_WAIT, with a simultaneous clear (set must win)
      eng_dl = 100;
      eng_dr = 3;
      pulse_valid(16'h0a0a, 16'h0b0b);
      repeat (20) @(negedge clk);
      valid   = 1'b1;
      lft_in  = 16'hdead;
      rht_in  = 16'hbeef;
      clr_err = 1'b1;
      @(negedge clk);
      valid   = 1'b0;
      clr_err = 1'b0;
      chk("ovr_set", 32'(err_ovr), 32'd1);
      chk("ovr_busy", 32'(busy), 32'd1);
      wait_idle("ovr");
      model_frame(16'h0a0a, 16'h0b0b, 100, 3);
      chk("ovr_lft_out", 32'(lft_out), 32'(m_out_l));
      chk("ovr_rht_out", 32'(rht_out), 32'(m_out_r));
      repeat (4) @(negedge clk);
      chk("ovr_dropped", 32'(busy), 32'd0);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("ovr_clr", 32'(err_ovr), 32'd0);

      // random frames, occasional timeouts
      for (int i = 0; i < 10; i++) begin
         int dl, dr;
         dl = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 30));
         dr = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 30));
         frame("rand", 16'($urandom), 16'($urandom), dl, dr);
      end

      // reset while waiting on the right channel
      eng_dl = 0;
      eng_dr = 50;
      a_l = 16'($urandom);
      a_r = 16'($urandom);
      pulse_valid(a_l, a_r);
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", 32'({lft_out, rht_out}), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_eng", 32'({eng_bus.eng_start, eng_bus.eng_ch, eng_bus.eng_din}), 32'd0);
      chk("mid_rst_errs", 32'({err_ovr, err_tmo}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         frame("rewarm", 16'($urandom), 16'($urandom), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 5)));
      end
      chk("rewarm_hold", 32'(hold_bad), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
